// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate encodings (common with os_checker),
// per-substate timeout lengths in milliseconds and the TX ordered-set selector.
package ltssm_pkg;

  // Substate encodings driven to os_checker and the TX ordered-set generator.
  localparam logic [3:0] DETECT_QUIET  = 4'd0;
  localparam logic [3:0] DETECT_ACTIVE = 4'd1;
  localparam logic [3:0] POLL_ACTIVE   = 4'd2;
  localparam logic [3:0] POLL_CONFIG   = 4'd3;
  localparam logic [3:0] CFG_LW_START  = 4'd4;
  localparam logic [3:0] CFG_LW_ACCEPT = 4'd5;
  localparam logic [3:0] CFG_LN_WAIT   = 4'd6;
  localparam logic [3:0] CFG_LN_ACCEPT = 4'd7;
  localparam logic [3:0] CFG_COMPLETE  = 4'd8;
  localparam logic [3:0] CFG_IDLE      = 4'd9;
  localparam logic [3:0] L0            = 4'd10;

  // Substate timeouts, in milliseconds.
  localparam int unsigned QUIET_MS       = 12;
  localparam int unsigned POLL_ACTIVE_MS = 24;
  localparam int unsigned POLL_CONFIG_MS = 48;
  localparam int unsigned CFG_START_MS   = 24;
  localparam int unsigned CFG_SHORT_MS   = 2;

  // Number of TS1 sets that must be sent before leaving Polling.Active.
  localparam int unsigned POLL_TX_MIN = 1024;

  // High when TX should send TS2 rather than TS1 in the given substate.
  // An upstream port already answers with TS2 during the lane-number handshake.
  function automatic logic sends_ts2(input logic [3:0] st, input logic upstream);
    logic r;
    r = (st == POLL_CONFIG) || (st == CFG_COMPLETE) || (st == CFG_IDLE);
    if (upstream && ((st == CFG_LN_WAIT) || (st == CFG_LN_ACCEPT))) begin
      r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Substate dwell timer: counts cycles since the last clear, saturates at its
// maximum and flags when the count equals the selected terminal value.
module ltssm_timeout_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_enable,
  input  logic [W-1:0] i_terminal,
  output logic         o_expired
);

  logic [W-1:0] r_count;

  // Cycle counter: cleared on substate entry, saturating so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == i_terminal);

endmodule

// File: rtl/ltssm_rx_sequencer.sv
// LTSSM substate sequencer for the RX ordered-set checker. Walks
// Detect -> Polling -> Configuration -> L0 from matched-RX counts, TX
// ordered-set counts and per-substate timeouts, and restarts the checker
// for one cycle after every substate change. The substate output doubles as
// the observable FSM state.
module ltssm_rx_sequencer
  import ltssm_pkg::*;
#(
  parameter int unsigned DEVICETYPE = 0,
  parameter int unsigned CLK_PER_MS = 1000,
  parameter int unsigned RX_REQ     = 8,
  parameter int unsigned TX_REQ     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       countup,
  input  logic       resetcounter,
  input  logic       rx_detect_done,
  input  logic       rx_detected,
  input  logic       tx_os_sent,
  output logic [3:0] substate,
  output logic       checker_rst_n,
  output logic       tx_ts2,
  output logic       linkup,
  output logic       timeout_pulse
);

  // The TX count must hold the 1024-set Polling.Active exit threshold, so it is
  // wider than the RX count; both saturate at their all-ones value.
  localparam int unsigned TXW = 11;

  localparam logic [23:0]    T_QUIET   = 24'(QUIET_MS * CLK_PER_MS);
  localparam logic [23:0]    T_PACTIVE = 24'(POLL_ACTIVE_MS * CLK_PER_MS);
  localparam logic [23:0]    T_PCONFIG = 24'(POLL_CONFIG_MS * CLK_PER_MS);
  localparam logic [23:0]    T_CSTART  = 24'(CFG_START_MS * CLK_PER_MS);
  localparam logic [23:0]    T_SHORT   = 24'(CFG_SHORT_MS * CLK_PER_MS);
  localparam logic [4:0]     RX_MIN    = 5'(RX_REQ);
  localparam logic [4:0]     RX_TWO    = 5'd2;
  localparam logic [TXW-1:0] TX_MIN    = TXW'(TX_REQ);
  localparam logic [TXW-1:0] TX_POLL   = TXW'(POLL_TX_MIN);

  logic           w_upstream;
  logic [3:0]     r_state;
  logic [4:0]     r_rx;
  logic [TXW-1:0] r_tx;
  logic           r_chk_rst_n;

  logic           w_exit;
  logic [3:0]     w_exit_to;
  logic           w_has_timeout;
  logic [23:0]    w_terminal;
  logic           w_expired;
  logic           w_timeout;
  logic [3:0]     w_next;
  logic           w_change;
  logic           w_rx_ok;
  logic           w_tx_ok;

  assign w_upstream = (DEVICETYPE != 0);
  assign w_rx_ok    = (r_rx >= RX_MIN);
  assign w_tx_ok    = (r_tx >= TX_MIN);

  // Per-substate exit condition, exit target and timeout length.
  always_comb begin
    w_exit        = 1'b0;
    w_exit_to     = r_state;
    w_has_timeout = 1'b1;
    w_terminal    = T_SHORT;
    case (r_state)
      DETECT_QUIET: begin
        // Quiet expiry is the normal way out, not a timeout event.
        w_has_timeout = 1'b0;
        w_terminal    = T_QUIET;
        w_exit        = w_expired;
        w_exit_to     = DETECT_ACTIVE;
      end
      DETECT_ACTIVE: begin
        w_has_timeout = 1'b0;
        w_exit        = rx_detect_done;
        w_exit_to     = rx_detected ? POLL_ACTIVE : DETECT_QUIET;
      end
      POLL_ACTIVE: begin
        w_terminal = T_PACTIVE;
        w_exit     = w_rx_ok && (r_tx >= TX_POLL);
        w_exit_to  = POLL_CONFIG;
      end
      POLL_CONFIG: begin
        w_terminal = T_PCONFIG;
        w_exit     = w_rx_ok && w_tx_ok;
        w_exit_to  = CFG_LW_START;
      end
      CFG_LW_START: begin
        w_terminal = T_CSTART;
        w_exit     = (r_rx >= RX_TWO);
        w_exit_to  = CFG_LW_ACCEPT;
      end
      CFG_LW_ACCEPT: begin
        // A downstream port proposed the link width itself and moves on at once.
        w_exit    = w_upstream ? (r_rx >= RX_TWO) : 1'b1;
        w_exit_to = CFG_LN_WAIT;
      end
      CFG_LN_WAIT: begin
        w_exit    = (r_rx >= RX_TWO);
        w_exit_to = CFG_LN_ACCEPT;
      end
      CFG_LN_ACCEPT: begin
        w_exit    = (r_rx >= RX_TWO);
        w_exit_to = CFG_COMPLETE;
      end
      CFG_COMPLETE: begin
        w_exit    = w_rx_ok && w_tx_ok;
        w_exit_to = CFG_IDLE;
      end
      CFG_IDLE: begin
        w_exit    = w_rx_ok && w_tx_ok;
        w_exit_to = L0;
      end
      L0: begin
        w_has_timeout = 1'b0;
      end
      default: begin
        // Unused encodings fall back to Detect.Quiet.
        w_has_timeout = 1'b0;
        w_exit        = 1'b1;
        w_exit_to     = DETECT_QUIET;
      end
    endcase
  end

  // An exit beats a timeout expiring in the same cycle.
  assign w_timeout = w_has_timeout && w_expired && !w_exit;
  assign w_next    = w_exit ? w_exit_to : (w_timeout ? DETECT_QUIET : r_state);
  assign w_change  = (w_next != r_state);

  ltssm_timeout_timer #(.W(24)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_change),
    .i_enable   (r_state != L0),
    .i_terminal (w_terminal),
    .o_expired  (w_expired)
  );

  // Substate register and the one-cycle checker restart after each change.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= DETECT_QUIET;
      r_chk_rst_n <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_chk_rst_n <= !w_change;
    end
  end

  // Matched-RX run length; countup is ignored while the checker restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx <= '0;
    end else if (w_change || !resetcounter) begin
      r_rx <= '0;
    end else if (countup && r_chk_rst_n && (r_rx != 5'h1f)) begin
      r_rx <= r_rx + 1'b1;
    end
  end

  // Ordered sets sent by TX since substate entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx <= '0;
    end else if (w_change) begin
      r_tx <= '0;
    end else if (tx_os_sent && (r_tx != {TXW{1'b1}})) begin
      r_tx <= r_tx + 1'b1;
    end
  end

  assign substate      = r_state;
  assign checker_rst_n = r_chk_rst_n;
  assign tx_ts2        = sends_ts2(r_state, w_upstream);
  assign linkup        = (r_state == L0);
  assign timeout_pulse = w_timeout;

endmodule

// File: tb/tb_ltssm_rx_sequencer.sv
// Directed bench for ltssm_rx_sequencer. Instance 0 is a fast downstream port
// (10 clk/ms) for detect timing and the Polling.Active timeout; instances 1
// (downstream) and 2 (upstream) use 100 clk/ms so the 1024-set Polling exit
// fits inside its 24 ms window, and walk the full path to L0.
module tb_ltssm_rx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_reset [3];
  logic       r_cu    [3];
  logic       r_rc    [3];
  logic       r_rdd   [3];
  logic       r_rdet  [3];
  logic       r_txs   [3];
  logic [3:0] w_sub   [3];
  logic       w_crn   [3];
  logic       w_ts2   [3];
  logic       w_lu    [3];
  logic       w_tp    [3];

  int n_vec = 0;
  int n_err = 0;

  ltssm_rx_sequencer #(.DEVICETYPE(0), .CLK_PER_MS(10)) u_fast (
    .clk(clk), .reset(r_reset[0]), .countup(r_cu[0]), .resetcounter(r_rc[0]),
    .rx_detect_done(r_rdd[0]), .rx_detected(r_rdet[0]), .tx_os_sent(r_txs[0]),
    .substate(w_sub[0]), .checker_rst_n(w_crn[0]), .tx_ts2(w_ts2[0]),
    .linkup(w_lu[0]), .timeout_pulse(w_tp[0]));

  ltssm_rx_sequencer #(.DEVICETYPE(0), .CLK_PER_MS(100)) u_dn (
    .clk(clk), .reset(r_reset[1]), .countup(r_cu[1]), .resetcounter(r_rc[1]),
    .rx_detect_done(r_rdd[1]), .rx_detected(r_rdet[1]), .tx_os_sent(r_txs[1]),
    .substate(w_sub[1]), .checker_rst_n(w_crn[1]), .tx_ts2(w_ts2[1]),
    .linkup(w_lu[1]), .timeout_pulse(w_tp[1]));

  ltssm_rx_sequencer #(.DEVICETYPE(1), .CLK_PER_MS(100)) u_up (
    .clk(clk), .reset(r_reset[2]), .countup(r_cu[2]), .resetcounter(r_rc[2]),
    .rx_detect_done(r_rdd[2]), .rx_detected(r_rdet[2]), .tx_os_sent(r_txs[2]),
    .substate(w_sub[2]), .checker_rst_n(w_crn[2]), .tx_ts2(w_ts2[2]),
    .linkup(w_lu[2]), .timeout_pulse(w_tp[2]));

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input int k, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL dut%0d %s: observed %0d expected %0d", k, tag, obs, exp);
    end
  endtask

  // Hold countup for n cycles.
  task automatic cup(input int k, input int n);
    r_cu[k] = 1'b1;
    ticks(n);
    r_cu[k] = 1'b0;
  endtask

  // Full bring-up from reset release to L0 on a 100 clk/ms instance.
  task automatic happy(input int k, input logic up);
    r_reset[k] = 1'b0;
    ticks(1201);
    chk(k, "quiet_to_active", 32'(w_sub[k]), 1);
    r_rdd[k] = 1'b1; r_rdet[k] = 1'b1;
    tick();
    r_rdd[k] = 1'b0; r_rdet[k] = 1'b0;
    chk(k, "enter_poll_active", 32'(w_sub[k]), 2);
    // 1024 TS1 sent and 8 counted matches (first countup falls in the restart cycle).
    r_cu[k] = 1'b1; r_txs[k] = 1'b1;
    ticks(9);
    r_cu[k] = 1'b0;
    ticks(1015);
    chk(k, "poll_hold_at_tx1023", 32'(w_sub[k]), 2);
    r_txs[k] = 1'b0;
    tick();
    chk(k, "enter_poll_config", 32'(w_sub[k]), 3);
    chk(k, "poll_config_ts2", 32'(w_ts2[k]), 1);
    // 7 matches, run broken, then 8 fresh matches needed.
    r_txs[k] = 1'b1;
    cup(k, 8);
    r_rc[k] = 1'b0;
    tick();
    r_rc[k] = 1'b1;
    cup(k, 7);
    chk(k, "rx7_after_clear", 32'(w_sub[k]), 3);
    cup(k, 1);
    chk(k, "rx8_registered", 32'(w_sub[k]), 3);
    r_txs[k] = 1'b0;
    tick();
    chk(k, "enter_lw_start", 32'(w_sub[k]), 4);
    chk(k, "lw_start_ts1", 32'(w_ts2[k]), 0);
    cup(k, 3);
    tick();
    chk(k, "enter_lw_accept", 32'(w_sub[k]), 5);
    if (up) begin
      cup(k, 3);
      tick();
    end else begin
      tick();
    end
    chk(k, "enter_ln_wait", 32'(w_sub[k]), 6);
    chk(k, "ln_wait_ts2", 32'(w_ts2[k]), 32'(up));
    // Exit becomes true exactly when the 2 ms timer hits terminal count.
    ticks(198);
    cup(k, 2);
    chk(k, "exit_vs_timeout_state", 32'(w_sub[k]), 6);
    chk(k, "exit_vs_timeout_pulse", 32'(w_tp[k]), 0);
    tick();
    chk(k, "enter_ln_accept", 32'(w_sub[k]), 7);
    chk(k, "ln_accept_ts2", 32'(w_ts2[k]), 32'(up));
    cup(k, 3);
    tick();
    chk(k, "enter_complete", 32'(w_sub[k]), 8);
    chk(k, "complete_ts2", 32'(w_ts2[k]), 1);
    r_cu[k] = 1'b1; r_txs[k] = 1'b1;
    ticks(16);
    r_cu[k] = 1'b0; r_txs[k] = 1'b0;
    tick();
    chk(k, "enter_idle", 32'(w_sub[k]), 9);
    chk(k, "idle_ts2", 32'(w_ts2[k]), 1);
    chk(k, "idle_no_linkup", 32'(w_lu[k]), 0);
    r_cu[k] = 1'b1; r_txs[k] = 1'b1;
    ticks(16);
    r_cu[k] = 1'b0; r_txs[k] = 1'b0;
    tick();
    chk(k, "enter_l0", 32'(w_sub[k]), 10);
    chk(k, "l0_linkup", 32'(w_lu[k]), 1);
    chk(k, "l0_ts1", 32'(w_ts2[k]), 0);
    ticks(5);
    chk(k, "l0_sticky", 32'(w_sub[k]), 10);
  endtask

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      r_reset[k] = 1'b1; r_cu[k] = 1'b0; r_rc[k] = 1'b1;
      r_rdd[k] = 1'b0; r_rdet[k] = 1'b0; r_txs[k] = 1'b0;
    end
    ticks(3);
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_substate", 32'(w_sub[k]), 0);
      chk(k, "rst_checker_rst_n", 32'(w_crn[k]), 0);
      chk(k, "rst_linkup", 32'(w_lu[k]), 0);
    end
    chk(0, "rst_tx_ts2", 32'(w_ts2[0]), 0);
    chk(0, "rst_timeout_pulse", 32'(w_tp[0]), 0);

    // Detect.Quiet lasts exactly 12 ms = 120 cycles, with no timeout pulse.
    r_reset[0] = 1'b0;
    ticks(120);
    chk(0, "quiet_hold_120", 32'(w_sub[0]), 0);
    chk(0, "quiet_expiry_no_pulse", 32'(w_tp[0]), 0);
    tick();
    chk(0, "quiet_to_active", 32'(w_sub[0]), 1);
    r_rdd[0] = 1'b1; r_rdet[0] = 1'b1;
    tick();
    r_rdd[0] = 1'b0; r_rdet[0] = 1'b0;
    chk(0, "enter_poll_active", 32'(w_sub[0]), 2);
    chk(0, "restart_low", 32'(w_crn[0]), 0);
    tick();
    chk(0, "restart_high_again", 32'(w_crn[0]), 1);
    chk(0, "poll_active_ts1", 32'(w_ts2[0]), 0);
    // Only 7 matches: Polling.Active times out after 240 cycles.
    cup(0, 7);
    ticks(231);
    chk(0, "poll_timer_239_no_pulse", 32'(w_tp[0]), 0);
    tick();
    chk(0, "poll_timer_240_state", 32'(w_sub[0]), 2);
    chk(0, "poll_timeout_pulse", 32'(w_tp[0]), 1);
    tick();
    chk(0, "poll_timeout_to_quiet", 32'(w_sub[0]), 0);
    chk(0, "pulse_single_cycle", 32'(w_tp[0]), 0);
    chk(0, "restart_after_timeout", 32'(w_crn[0]), 0);
    // Receiver detect with nobody present returns to Detect.Quiet.
    ticks(121);
    chk(0, "requiet_to_active", 32'(w_sub[0]), 1);
    r_rdd[0] = 1'b1; r_rdet[0] = 1'b0;
    tick();
    r_rdd[0] = 1'b0;
    chk(0, "no_receiver_to_quiet", 32'(w_sub[0]), 0);

    happy(1, 1'b0);
    happy(2, 1'b1);

    // Reset in L0 returns everything to reset values on the next edge.
    r_reset[2] = 1'b1;
    tick();
    chk(2, "midrst_substate", 32'(w_sub[2]), 0);
    chk(2, "midrst_linkup", 32'(w_lu[2]), 0);
    chk(2, "midrst_checker_rst_n", 32'(w_crn[2]), 0);
    ticks(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
